sd2vc_tx: RTL and testbench

Transmit-side converter from an srdy/drdy interface to a valid/credit interface, the producer end of a valid/credit link whose far end drains into a FIFO of `depth` entries. It tracks available credits, forwards one word per credit, and opens the link with a post-reset wakeup handshake. Until that handshake completes and the first credit returns, it sends no data. It sits on the sending side of any chip- or partition-crossing valid/credit channel in sdlib.

---
 rtl/sdlib_vc_pkg.sv | 16 +
 rtl/sd2vc_tx_if.sv | 14 +
 rtl/vc_credit_ctr.sv | 33 +++
 rtl/sd2vc_tx.sv | 109 ++++++++++
 tb/tb_sd2vc_tx.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/sdlib_vc_pkg.sv
// Shared definitions for both ends of the sdlib valid/credit link.
// The state encodings cover the link-opening phase only. The terminal run phase is a separate flag.
package sdlib_vc_pkg;

    localparam logic [1:0] s_idle  = 2'd0;
    localparam logic [1:0] s_wake0 = 2'd1;
    localparam logic [1:0] s_wake1 = 2'd2;
    localparam logic [1:0] s_wait  = 2'd3;

    localparam int unsigned wakeup_pattern_def = 1;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sd2vc_tx_if.sv
// Bundles the upstream srdy/drdy port and the downstream valid/credit link of sd2vc_tx.
// master is the converter's view. slave is the view of the surrounding logic.
interface sd2vc_tx_if #(parameter int width = 8) ();
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;
  logic             p_vld;
  logic [width-1:0] p_data;
  logic             p_cr;
  logic             err_ovf;

  modport master (input c_srdy, c_data, p_cr, output c_drdy, p_vld, p_data, err_ovf);
  modport slave  (output c_srdy, c_data, p_cr, input c_drdy, p_vld, p_data, err_ovf);
endinterface

// File: rtl/vc_credit_ctr.sv
// Saturating credit counter with a sticky overflow flag. The counter updates one cycle after inc/dec.
// A simultaneous inc and dec cancel each other. An inc at full count without dec saturates the count and sets ovf.
module vc_credit_ctr #(
  parameter int depth = 16,
  localparam int cw = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          en,
  output logic [cw-1:0] count,
  output logic          nonzero,
  output logic          ovf
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (inc && !dec) begin
        if (count == cw'(depth)) ovf <= 1'b1;
        else                     count <= count + 1'b1;
      end else if (dec && !inc) begin
        count <= count - 1'b1;
      end
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/sd2vc_tx.sv
// Converts srdy/drdy to valid/credit on the producer side. It opens the link with a wakeup handshake.
// Data latency is 1 cycle. c_drdy is low until the first credit arrives and whenever no credits are left.
// Optional macro SDLIB_SD2VC_REGINP_EN registers p_cr before any use.
module sd2vc_tx
  import sdlib_vc_pkg::*;
#(
  parameter int               depth          = 16,
  parameter int               width          = 8,
  parameter logic [width-1:0] wakeup_pattern = width'(wakeup_pattern_def),
  parameter int               wake_gap       = 16
) (
  input  logic         clk,
  input  logic         reset,
  sd2vc_tx_if.master   link
);

  localparam int cw = cnt_width(depth);
  localparam int gw = cnt_width(wake_gap);

  logic [1:0]    state;
  logic          run;
  logic [gw-1:0] gap;
  logic          cr;
  logic          xfer;
  logic          cnt_en;
  logic          crnz;
  logic [cw-1:0] crcnt;
  logic          unused_crcnt;

`ifdef SDLIB_SD2VC_REGINP_EN
  logic cr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cr_q <= 1'b0;
    else        cr_q <= link.p_cr;
  end
  assign cr = cr_q;
`else
  assign cr = link.p_cr;
`endif

  assign link.c_drdy = run & crnz;
  assign xfer        = link.c_srdy & link.c_drdy;
  assign cnt_en      = run | (state == s_wait);
  assign unused_crcnt = ^crcnt;

  vc_credit_ctr #(.depth(depth)) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc     (cr),
    .dec     (xfer),
    .en      (cnt_en),
    .count   (crcnt),
    .nonzero (crnz),
    .ovf     (link.err_ovf)
  );

  // When run is set, state freezes at s_wait. Only the data path is active after that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= s_idle;
      run         <= 1'b0;
      gap         <= gw'(wake_gap);
      link.p_vld  <= 1'b0;
      link.p_data <= '0;
    end else begin
      link.p_vld <= 1'b0;
      if (run) begin
        if (xfer) begin
          link.p_vld  <= 1'b1;
          link.p_data <= link.c_data;
        end
      end else begin
        case (state)
          s_idle: begin
            if (gap == gw'(1)) begin
              state       <= s_wake0;
              link.p_vld  <= 1'b1;
              link.p_data <= wakeup_pattern;
            end else begin
              gap <= gap - 1'b1;
            end
          end
          s_wake0: begin
            state       <= s_wake1;
            link.p_vld  <= 1'b1;
            link.p_data <= ~wakeup_pattern;
          end
          s_wake1: begin
            state <= s_wait;
            gap   <= gw'(wake_gap);
          end
          s_wait: begin
            // A credit takes priority over an expiring retry timer.
            if (cr) begin
              run <= 1'b1;
            end else if (gap == gw'(1)) begin
              state       <= s_wake0;
              link.p_vld  <= 1'b1;
              link.p_data <= wakeup_pattern;
            end else begin
              gap <= gap - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd2vc_tx.sv
// Bench for sd2vc_tx with depth=4, width=8, wakeup_pattern=1, and wake_gap=16.
// The expected link activity comes from cycle arithmetic and a credit-balance model.
module tb_sd2vc_tx;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int         cyc;
  bit         m_run;
  int         m_cred;
  bit         m_ovf;
  logic [7:0] m_last;
  bit         m_crq;

  sd2vc_tx_if #(.width(8)) link ();

  sd2vc_tx #(.depth(DEPTH), .width(8), .wakeup_pattern(8'h01), .wake_gap(16)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_run = 0; m_cred = 0; m_ovf = 0; m_last = 8'h00; m_crq = 0;
  endtask

  // This task is entered #1 after a rising edge. It drives one cycle of inputs, checks the outputs, and then returns #1 after the next edge.
  task automatic step(input bit srdy, input logic [7:0] d, input bit cr, output bit xf);
    bit cr_m, in_wait, cnt, ev;
    int k;
    logic [7:0] ed;
    link.c_srdy = srdy; link.c_data = d; link.p_cr = cr;
    #1;
    chk("c_drdy", 32'(link.c_drdy), 32'(m_run && m_cred > 0));
    xf = srdy && m_run && (m_cred > 0);
`ifdef SDLIB_SD2VC_REGINP_EN
    cr_m = m_crq; m_crq = cr;
`else
    cr_m = cr;
`endif
    // The link waits for credits during edges 18..33 after release, and it repeats this every 18 cycles.
    in_wait = !m_run && cyc >= 18 && ((cyc - 18) % 18) < 16;
    cnt = cr_m && (m_run || in_wait);
    if (cnt && !xf && m_cred == DEPTH) m_ovf = 1;
    else m_cred = m_cred + int'(cnt) - int'(xf);
    if (cnt) m_run = 1;
    @(posedge clk); #1; cyc++;
    ev = 0; ed = m_last;
    if (xf) begin
      ev = 1; ed = d;
    end else if (!m_run && cyc >= 16) begin
      k = (cyc - 16) % 18;
      if (k == 0) begin ev = 1; ed = 8'h01; end
      if (k == 1) begin ev = 1; ed = 8'hFE; end
    end
    m_last = ed;
    chk("p_vld", 32'(link.p_vld), 32'(ev));
    chk("p_data", 32'(link.p_data), 32'(ed));
    chk("err_ovf", 32'(link.err_ovf), 32'(m_ovf));
  endtask

  initial begin
    bit xf;
    int nx;
    reset = 1'b0;
    link.c_srdy = 0; link.c_data = 0; link.p_cr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p_vld", 32'(link.p_vld), 0);
    chk("rst_p_data", 32'(link.p_data), 0);
    chk("rst_c_drdy", 32'(link.c_drdy), 0);
    chk("rst_err_ovf", 32'(link.err_ovf), 0);
    reset = 1'b1;

    // There are no credits in this phase, so wakeups occur at 16/17, 34/35, and 52/53.
    repeat (54) step(0, 8'h00, 0, xf);

    // This phase gives four credits while upstream is always ready.
    nx = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 8'h10 + 8'(nx), i < 4, xf);
      if (xf) nx++;
    end
    chk("burst_count", 32'(nx), 4);

    // This phase fills the credit counter and then overflows it.
    repeat (5) step(0, 8'h00, 1, xf);
    step(0, 8'h00, 1, xf);
    chk("ovf_set", 32'(link.err_ovf), 1);
    for (int i = 0; i < 150; i++)
      step(1'($urandom), 8'($urandom), ($urandom % 3) == 0, xf);

    // This phase applies reset in the middle of a burst.
    repeat (3) step(1, 8'($urandom), 1, xf);
    chk("pre_rst_vld", 32'(link.p_vld), 1);
    link.p_cr = 0; link.c_srdy = 0;
    reset = 1'b0;
    #1;
    chk("async_p_vld", 32'(link.p_vld), 0);
    chk("async_c_drdy", 32'(link.c_drdy), 0);
    chk("async_err_ovf", 32'(link.err_ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (18) step(0, 8'h00, 0, xf);

    // This phase uses random traffic, including credits that arrive while the link is still opening.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), ($urandom % 6) == 0, xf);

    // This phase drains all credits and then measures the latency from credit to ready.
    repeat (8) step(1, 8'($urandom), 0, xf);
    if (m_run && m_cred == 0) begin
      step(0, 8'h00, 1, xf);
`ifdef SDLIB_SD2VC_REGINP_EN
      chk("cr_lat_t1", 32'(link.c_drdy), 0);
      step(0, 8'h00, 0, xf);
      chk("cr_lat_t2", 32'(link.c_drdy), 1);
`else
      chk("cr_lat_t1", 32'(link.c_drdy), 1);
`endif
    end else begin
      chk("cr_lat_setup", 32'(m_cred), 0);
    end
    repeat (4) step(0, 8'h00, 0, xf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
